// File: rtl/replay_pkg.sv
// Shared types and constants for the UART record/replay controller.
package replay_pkg;

    typedef enum logic [2:0] {
        ST_RECORD = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_XMIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        HS_IDLE    = 2'd0,
        HS_SEND    = 2'd1,
        HS_SETTLE  = 2'd2,
        HS_WAIT_TX = 2'd3
    } hs_state_t;

    localparam logic [7:0] MARKER_DEFAULT = 8'h30;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/replay_tx_handshake.sv
// Start/busy handshake toward the UART transmitter: SEND, SETTLE and WAIT_TX phases.
module replay_tx_handshake
    import replay_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_issue,
    input  logic [7:0] i_byte,
    input  logic       i_tx_busy,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_done
);

    hs_state_t  r_hs, w_hs_nxt;
    logic       r_tx_start, w_tx_start_nxt;
    logic [7:0] r_tx_data, w_tx_data_nxt;
    logic [7:0] r_pend, w_pend_nxt;

    // Next-state logic; tx_data only moves together with tx_start so an in-flight frame keeps its byte
    always_comb begin
        w_hs_nxt       = r_hs;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_pend_nxt     = r_pend;
        o_done         = 1'b0;
        if (i_clear) begin
            w_hs_nxt = HS_IDLE;
        end else begin
            case (r_hs)
                HS_IDLE: begin
                    if (i_issue) begin
                        w_pend_nxt = i_byte;
                        w_hs_nxt   = HS_SEND;
                    end else begin
                        w_hs_nxt = HS_IDLE;
                    end
                end
                HS_SEND: begin
                    if (!i_tx_busy) begin
                        w_tx_start_nxt = 1'b1;
                        w_tx_data_nxt  = r_pend;
                        w_hs_nxt       = HS_SETTLE;
                    end else begin
                        w_hs_nxt = HS_SEND;
                    end
                end
                HS_SETTLE: w_hs_nxt = HS_WAIT_TX;
                HS_WAIT_TX: begin
                    if (!i_tx_busy) begin
                        o_done   = 1'b1;
                        w_hs_nxt = HS_IDLE;
                    end else begin
                        w_hs_nxt = HS_WAIT_TX;
                    end
                end
                default: w_hs_nxt = HS_IDLE;
            endcase
        end
    end

    // Handshake state and transmitter-facing registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs       <= HS_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_pend     <= 8'h00;
        end else begin
            r_hs       <= w_hs_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_pend     <= w_pend_nxt;
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;

endmodule

// File: rtl/replay_controller.sv
// Record/replay scheduler: stores received bytes in an external RAM, replays them to the UART TX.
// Build option REPLAY_LOOP_EN: replay restarts from the first byte forever until clear.
module replay_controller
    import replay_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter logic [7:0]  MARKER = MARKER_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [7:0]        mem_rdata,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              record_en,
    output logic              replay_start,
    output logic              replay_en,
    output logic              overflow
);

    localparam int unsigned     DEPTH    = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state, w_state_nxt;
    logic [ADDR_W:0]   r_wr_cnt, w_wr_cnt_nxt, r_len, w_len_nxt, r_rd_ptr, w_rd_ptr_nxt;
    logic [ADDR_W:0]   w_rd_inc;
    logic              r_mem_we, w_mem_we_nxt, r_mem_re, w_mem_re_nxt;
    logic [ADDR_W-1:0] r_mem_waddr, w_mem_waddr_nxt, r_mem_raddr, w_mem_raddr_nxt;
    logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;
    logic              r_replay_start, w_replay_start_nxt, r_overflow, w_overflow_nxt;
    logic              r_record_en, r_replay_en, w_record_en_nxt;
    logic              w_issue, w_done;

    assign w_rd_inc = r_rd_ptr + CNT_ONE;

    replay_tx_handshake u_hs (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (clear),
        .i_issue    (w_issue),
        .i_byte     (mem_rdata),
        .i_tx_busy  (tx_busy),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data),
        .o_done     (w_done)
    );

    // Next-state and next-output logic; mem_re is raised on entry to FETCH so read data lands in LATCH
    always_comb begin
        w_state_nxt        = r_state;
        w_wr_cnt_nxt       = r_wr_cnt;
        w_len_nxt          = r_len;
        w_rd_ptr_nxt       = r_rd_ptr;
        w_mem_we_nxt       = 1'b0;
        w_mem_waddr_nxt    = r_mem_waddr;
        w_mem_wdata_nxt    = r_mem_wdata;
        w_mem_re_nxt       = 1'b0;
        w_mem_raddr_nxt    = r_mem_raddr;
        w_replay_start_nxt = 1'b0;
        w_overflow_nxt     = r_overflow;
        w_issue            = 1'b0;
        if (clear) begin
            w_state_nxt    = ST_RECORD;
            w_wr_cnt_nxt   = CNT_ZERO;
            w_len_nxt      = CNT_ZERO;
            w_rd_ptr_nxt   = CNT_ZERO;
            w_overflow_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_RECORD: begin
                    if (!rx_ready) begin
                        w_state_nxt = ST_RECORD;
                    end else if (rx_data == MARKER) begin
                        w_len_nxt          = r_wr_cnt;
                        w_rd_ptr_nxt       = CNT_ZERO;
                        w_replay_start_nxt = 1'b1;
                        if (r_wr_cnt == CNT_ZERO) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt     = ST_FETCH;
                            w_mem_re_nxt    = 1'b1;
                            w_mem_raddr_nxt = {ADDR_W{1'b0}};
                        end
                    end else if (r_wr_cnt == FULL_CNT) begin
                        w_overflow_nxt = 1'b1;
                    end else begin
                        w_mem_we_nxt    = 1'b1;
                        w_mem_waddr_nxt = r_wr_cnt[ADDR_W-1:0];
                        w_mem_wdata_nxt = rx_data;
                        w_wr_cnt_nxt    = r_wr_cnt + CNT_ONE;
                    end
                end
                ST_FETCH: w_state_nxt = ST_LATCH;
                ST_LATCH: begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_XMIT;
                end
                ST_XMIT: begin
                    if (!w_done) begin
                        w_state_nxt = ST_XMIT;
                    end else if (w_rd_inc == r_len) begin
`ifdef REPLAY_LOOP_EN
                        w_rd_ptr_nxt    = CNT_ZERO;
                        w_state_nxt     = ST_FETCH;
                        w_mem_re_nxt    = 1'b1;
                        w_mem_raddr_nxt = {ADDR_W{1'b0}};
`else
                        w_rd_ptr_nxt = w_rd_inc;
                        w_state_nxt  = ST_DONE;
`endif
                    end else begin
                        w_rd_ptr_nxt    = w_rd_inc;
                        w_state_nxt     = ST_FETCH;
                        w_mem_re_nxt    = 1'b1;
                        w_mem_raddr_nxt = w_rd_inc[ADDR_W-1:0];
                    end
                end
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_RECORD;
            endcase
        end
        w_record_en_nxt = (w_state_nxt == ST_RECORD);
    end

    // State, counters and every registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RECORD;
            r_wr_cnt       <= CNT_ZERO;
            r_len          <= CNT_ZERO;
            r_rd_ptr       <= CNT_ZERO;
            r_mem_we       <= 1'b0;
            r_mem_waddr    <= {ADDR_W{1'b0}};
            r_mem_wdata    <= 8'h00;
            r_mem_re       <= 1'b0;
            r_mem_raddr    <= {ADDR_W{1'b0}};
            r_replay_start <= 1'b0;
            r_overflow     <= 1'b0;
            r_record_en    <= 1'b1;
            r_replay_en    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_wr_cnt       <= w_wr_cnt_nxt;
            r_len          <= w_len_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_mem_we       <= w_mem_we_nxt;
            r_mem_waddr    <= w_mem_waddr_nxt;
            r_mem_wdata    <= w_mem_wdata_nxt;
            r_mem_re       <= w_mem_re_nxt;
            r_mem_raddr    <= w_mem_raddr_nxt;
            r_replay_start <= w_replay_start_nxt;
            r_overflow     <= w_overflow_nxt;
            r_record_en    <= w_record_en_nxt;
            r_replay_en    <= !w_record_en_nxt;
        end
    end

    assign mem_we       = r_mem_we;
    assign mem_waddr    = r_mem_waddr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_re       = r_mem_re;
    assign mem_raddr    = r_mem_raddr;
    assign record_en    = r_record_en;
    assign replay_start = r_replay_start;
    assign replay_en    = r_replay_en;
    assign overflow     = r_overflow;

endmodule

// File: doc/replay_controller.md
Name: replay_controller

Overview:
- Record/replay scheduler for the UART sandbox.
- In RECORD it writes incoming serial bytes into an external single-port-per-side byte RAM.
- On the end-of-sequence marker it switches to REPLAY: it reads the stored bytes back in order and hands them one at a time to the UART transmitter using a start/busy handshake.
- Sits between the UART receiver, the buffer RAM and the UART transmitter.

Parameters:
- ADDR_W, 8, RAM address width; buffer depth DEPTH = 2**ADDR_W bytes.
- MARKER, 8'h30 ("0"), byte that ends recording; it is not stored.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous one-cycle pulse; abort and restart recording.
- rx_ready  input  1  one-cycle strobe: rx_data valid.
- rx_data  input  8  received byte.
- mem_we  output  1  RAM write enable.
- mem_waddr  output  ADDR_W  RAM write address.
- mem_wdata  output  8  RAM write data.
- mem_re  output  1  RAM read enable.
- mem_raddr  output  ADDR_W  RAM read address.
- mem_rdata  input  8  RAM read data, valid exactly 1 cycle after mem_re.
- tx_start  output  1  one-cycle pulse: transmit tx_data.
- tx_data  output  8  byte to transmit; held stable from tx_start until the transmitter is idle again.
- tx_busy  input  1  transmitter busy; rises no later than 1 cycle after tx_start.
- record_en  output  1  high in RECORD.
- replay_start  output  1  one-cycle pulse on the RECORD->replay transition.
- replay_en  output  1  high in every replay state and in DONE.
- overflow  output  1  sticky: a byte was dropped because the buffer was full.

Behaviour:
- Reset values:
  - state=RECORD, wr_cnt=0, rd_ptr=0, len=0.
  - All outputs 0 except record_en=1.
  - tx_data=0, mem_* addresses 0.
- States: RECORD, FETCH, LATCH, SEND, SETTLE, WAIT_TX, DONE.
- All outputs are registered.
- wr_cnt and len are ADDR_W+1 bits wide; full is defined as wr_cnt==DEPTH.
- RECORD:
  - rx_ready with rx_data!=MARKER and not full: mem_we=1 next cycle, mem_waddr=wr_cnt[ADDR_W-1:0], mem_wdata=rx_data, wr_cnt+1.
  - rx_ready with rx_data!=MARKER and full: byte dropped, overflow<=1, no write.
  - rx_ready with rx_data==MARKER: len<=wr_cnt, rd_ptr<=0, replay_start pulses 1 cycle, replay_en<=1, record_en<=0.
    - len==0 -> DONE.
    - Otherwise -> FETCH.
- FETCH: mem_re=1, mem_raddr=rd_ptr -> LATCH.
- LATCH: tx_data<=mem_rdata -> SEND.
- SEND: wait while tx_busy. When !tx_busy: tx_start=1 for 1 cycle, rd_ptr+1 -> SETTLE.
- SETTLE: one dead cycle to absorb the transmitter's busy latency -> WAIT_TX.
- WAIT_TX: wait until !tx_busy.
  - rd_ptr==len -> DONE.
  - Otherwise -> FETCH.
- Throughput: at most one byte per (transmitter frame + 4) cycles.
- DONE: idle, replay_en=1, tx_start=0. Stays until clear or reset.
- rx_ready outside RECORD: ignored, never written.
- clear, in any state:
  - Next state RECORD, wr_cnt=0, rd_ptr=0, len=0, overflow=0.
  - All strobes deasserted; record_en=1, replay_en=0.
  - An in-flight tx frame is not aborted (transmitter-owned).
  - clear coincident with rx_ready: clear wins, the byte is dropped.
  - clear coincident with the marker: no replay_start.
- Asynchronous reset mid-replay: everything returns to reset values immediately; stored RAM contents are not used again.
- mem_we and mem_re are never asserted in the same cycle.
- tx_start is never asserted while tx_busy=1.

Optional Feature:
- Macro: REPLAY_LOOP_EN.
- Defined: from WAIT_TX with rd_ptr==len, go to FETCH with rd_ptr<=0. Replay repeats indefinitely until clear. len==0 still goes to DONE.
- Undefined: single pass, then DONE as above.

Decomposition:
- Shared package replay_pkg:
  - State enum typedef.
  - Default MARKER constant.
  - Localparam helper for DEPTH from ADDR_W.
- One natural sub-module: replay_tx_handshake, which owns SEND/SETTLE/WAIT_TX, tx_start generation and the tx_busy wait. The top FSM issues a byte and receives a done pulse.
- RAM stays external.

Test Plan:
- Record then replay: send "A","B","C","0" -> RAM addr 0..2 = 41,42,43; one replay_start pulse; tx_start three times with tx_data 41,42,43 in order, each only when tx_busy=0; then DONE, replay_en=1.
- Empty sequence: "0" right after reset -> replay_start pulse, DONE, no mem_re, no tx_start.
- Overflow (ADDR_W=2): send 6 non-marker bytes then "0" -> only first 4 written, overflow=1, exactly 4 bytes transmitted.
- Backpressure: hold tx_busy=1 for 50 cycles after each tx_start -> no second tx_start before tx_busy falls; tx_data stable throughout.
- clear mid-replay after 1 of 3 bytes sent -> record_en=1, overflow=0, no further tx_start; new "X","0" replays only 58.
- REPLAY_LOOP_EN defined: "A","0" with tx_busy pulsing -> tx_data 41 transmitted repeatedly (at least 3 times), never DONE until clear.
